// File: rtl/spark_pwm_pkg.sv
// Shared SparkMax PWM timing defaults and the high-time clamp used by every channel.
package spark_pwm_pkg;

    localparam int SPK_PERIOD   = 4096;
    localparam int SPK_CENTER   = 633;
    localparam int SPK_MIN_HIGH = 378;
    localparam int SPK_MAX_HIGH = 888;

    function automatic int clamp_high(input int raw, input int lo, input int hi);
        if (raw < lo) return lo;
        if (raw > hi) return hi;
        return raw;
    endfunction

endpackage

// File: rtl/spark_pwm_chan.sv
// One SparkMax PWM channel: request capture, clamp, per-frame ramp, done/busy handshake
// and the registered pulse output compared against the shared frame counter.
module spark_pwm_chan
    import spark_pwm_pkg::*;
#(
    parameter int CNT_W     = 12,
    parameter int RATIO_W   = 8,
    parameter int CENTER    = SPK_CENTER,
    parameter int MIN_HIGH  = SPK_MIN_HIGH,
    parameter int MAX_HIGH  = SPK_MAX_HIGH,
    parameter int RAMP_STEP = 8
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               i_wrap,
    input  logic [CNT_W-1:0]   i_cnt,
    input  logic               i_enable,
    input  logic [RATIO_W-1:0] i_ratio,
    input  logic               i_dir,
    input  logic               i_update,
    output logic               o_done,
    output logic               o_busy,
    output logic               o_sig
);

    localparam logic [CNT_W-1:0] CTR = CNT_W'(CENTER);

    logic [CNT_W-1:0] r_cur, r_tgt, r_req;
    logic             r_act, r_pend, r_busy, r_done, r_sig;
    logic [CNT_W-1:0] w_clamped, w_req_n, w_tgt_n, w_cur_n;
    logic             w_pend_n;
    int               w_raw, w_diff;

    // A request arriving on the boundary cycle is folded into this boundary's target.
    always_comb begin
        w_raw     = i_dir ? CENTER + int'(i_ratio) : CENTER - int'(i_ratio);
        w_clamped = CNT_W'(clamp_high(w_raw, MIN_HIGH, MAX_HIGH));
        w_req_n   = i_update ? w_clamped : r_req;
        w_pend_n  = i_update | r_pend;
        w_tgt_n   = w_pend_n ? w_req_n : r_tgt;
        w_diff    = int'(w_tgt_n) - int'(r_cur);
        if (RAMP_STEP == 0 || (w_diff <= RAMP_STEP && w_diff >= -RAMP_STEP))
            w_cur_n = w_tgt_n;
        else if (w_diff > 0)
            w_cur_n = r_cur + CNT_W'(RAMP_STEP);
        else
            w_cur_n = r_cur - CNT_W'(RAMP_STEP);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_cur  <= CTR;
            r_tgt  <= CTR;
            r_req  <= CTR;
            r_act  <= 1'b0;
            r_pend <= 1'b0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
            r_sig  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_sig  <= r_act && (i_cnt < r_cur);
            if (i_wrap) begin
                r_act  <= i_enable;
                r_pend <= 1'b0;
                r_req  <= w_req_n;
                if (i_enable) begin
                    r_tgt <= w_tgt_n;
                    r_cur <= w_cur_n;
                    if ((r_busy | i_update) && (w_cur_n == w_tgt_n)) begin
                        r_done <= 1'b1;
                        r_busy <= 1'b0;
                    end else begin
                        r_busy <= r_busy | i_update;
                    end
                end else begin
                    // Disabled channels park at neutral and drop any outstanding request.
                    r_tgt  <= CTR;
                    r_cur  <= CTR;
                    r_busy <= 1'b0;
                end
            end else if (i_update) begin
                r_req  <= w_clamped;
                r_pend <= 1'b1;
                r_busy <= 1'b1;
            end
        end
    end

    assign o_done = r_done;
    assign o_busy = r_busy;
    assign o_sig  = r_sig;

endmodule

// File: rtl/spark_pwm_multi.sv
// NUM_CH SparkMax PWM channels sharing one frame counter so all pulses start together.
module spark_pwm_multi
    import spark_pwm_pkg::*;
#(
    parameter int NUM_CH    = 4,
    parameter int CNT_W     = 12,
    parameter int PERIOD    = SPK_PERIOD,
    parameter int RATIO_W   = 8,
    parameter int CENTER    = SPK_CENTER,
    parameter int MIN_HIGH  = SPK_MIN_HIGH,
    parameter int MAX_HIGH  = SPK_MAX_HIGH,
    parameter int RAMP_STEP = 8
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic [NUM_CH-1:0]         pwm_enable,
    input  logic [NUM_CH*RATIO_W-1:0] pwm_ratio,
    input  logic [NUM_CH-1:0]         pwm_direction,
    input  logic [NUM_CH-1:0]         pwm_update,
    output logic [NUM_CH-1:0]         pwm_done,
    output logic [NUM_CH-1:0]         pwm_busy,
    output logic [NUM_CH-1:0]         pwm_signal,
    output logic                      frame_start
);

    logic [CNT_W-1:0] r_cnt;
    logic             r_fs;
    logic             w_wrap;

    assign w_wrap = (r_cnt == CNT_W'(PERIOD - 1));

    // frame_start is registered from the wrap so it is high exactly while the counter is 0.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= '0;
            r_fs  <= 1'b0;
        end else begin
            r_cnt <= w_wrap ? '0 : r_cnt + 1'b1;
            r_fs  <= w_wrap;
        end
    end

    assign frame_start = r_fs;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        spark_pwm_chan #(
            .CNT_W    (CNT_W),
            .RATIO_W  (RATIO_W),
            .CENTER   (CENTER),
            .MIN_HIGH (MIN_HIGH),
            .MAX_HIGH (MAX_HIGH),
            .RAMP_STEP(RAMP_STEP)
        ) u_chan (
            .clock   (clock),
            .reset_n (reset_n),
            .i_wrap  (w_wrap),
            .i_cnt   (r_cnt),
            .i_enable(pwm_enable[g]),
            .i_ratio (pwm_ratio[g*RATIO_W +: RATIO_W]),
            .i_dir   (pwm_direction[g]),
            .i_update(pwm_update[g]),
            .o_done  (pwm_done[g]),
            .o_busy  (pwm_busy[g]),
            .o_sig   (pwm_signal[g])
        );
    end

endmodule

// File: tb/tb_spark_pwm_multi.sv
// Bench for spark_pwm_multi: a ramped (step 8) and an unramped (step 0) instance share stimulus;
// a frame-level model predicts every output each cycle, and per-frame tallies pin literal values.
module tb_spark_pwm_multi;

    localparam int P = 4096;
    localparam int NF = 16;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic [3:0]  pwm_enable = '0;
    logic [31:0] pwm_ratio = '0;
    logic [3:0]  pwm_direction = '0;
    logic [3:0]  pwm_update = '0;
    logic [3:0]  done8, busy8, sig8, done0, busy0, sig0;
    logic        fs8, fs0;

    spark_pwm_multi #(.RAMP_STEP(8)) dut (
        .clock(clock), .reset_n(reset_n), .pwm_enable(pwm_enable), .pwm_ratio(pwm_ratio),
        .pwm_direction(pwm_direction), .pwm_update(pwm_update), .pwm_done(done8),
        .pwm_busy(busy8), .pwm_signal(sig8), .frame_start(fs8));

    spark_pwm_multi #(.RAMP_STEP(0)) dut0 (
        .clock(clock), .reset_n(reset_n), .pwm_enable(pwm_enable), .pwm_ratio(pwm_ratio),
        .pwm_direction(pwm_direction), .pwm_update(pwm_update), .pwm_done(done0),
        .pwm_busy(busy0), .pwm_signal(sig0), .frame_start(fs0));

    always #5 clock = ~clock;

    int n_vec = 0;
    int n_err = 0;
    int bcyc = 0;

    // model state, index 0 = ramped instance, 1 = unramped instance
    int m_cur[2][4], m_tgt[2][4], m_req[2][4];
    bit m_act[2][4], m_pend[2][4], m_busy[2][4], m_done[2][4];
    int hist[2][4][NF], dh[2][4][NF], bh[2][4][NF];
    int hc[2][4], dc[2][4], bc[2][4];

    int md_raw, md_d, md_rs;
    bit md_bnd;

    initial begin
        forever begin
            @(posedge clock or negedge reset_n);
            if (!reset_n) begin
                bcyc = 0;
                for (int k = 0; k < 2; k++)
                    for (int i = 0; i < 4; i++) begin
                        m_cur[k][i] = 633; m_tgt[k][i] = 633; m_req[k][i] = 633;
                        m_act[k][i] = 0; m_pend[k][i] = 0; m_busy[k][i] = 0; m_done[k][i] = 0;
                    end
            end else begin
                md_bnd = ((bcyc % P) == P - 1);
                for (int k = 0; k < 2; k++) begin
                    md_rs = (k == 0) ? 8 : 0;
                    for (int i = 0; i < 4; i++) begin
                        m_done[k][i] = 0;
                        if (pwm_update[i]) begin
                            md_raw = pwm_direction[i] ? 633 + int'(pwm_ratio[i*8 +: 8])
                                                      : 633 - int'(pwm_ratio[i*8 +: 8]);
                            m_req[k][i] = (md_raw < 378) ? 378 : (md_raw > 888) ? 888 : md_raw;
                            m_pend[k][i] = 1;
                            m_busy[k][i] = 1;
                        end
                        if (md_bnd) begin
                            m_act[k][i] = pwm_enable[i];
                            if (pwm_enable[i]) begin
                                if (m_pend[k][i]) begin m_tgt[k][i] = m_req[k][i]; m_pend[k][i] = 0; end
                                md_d = m_tgt[k][i] - m_cur[k][i];
                                if (md_rs == 0 || (md_d <= md_rs && md_d >= -md_rs)) m_cur[k][i] = m_tgt[k][i];
                                else m_cur[k][i] += (md_d > 0) ? md_rs : -md_rs;
                                if (m_busy[k][i] && m_cur[k][i] == m_tgt[k][i]) begin
                                    m_done[k][i] = 1; m_busy[k][i] = 0;
                                end
                            end else begin
                                m_cur[k][i] = 633; m_tgt[k][i] = 633; m_pend[k][i] = 0; m_busy[k][i] = 0;
                            end
                        end
                    end
                end
                bcyc++;
            end
        end
    end

    logic [3:0] c_ed, c_eb, c_es, c_ad, c_ab, c_as;
    logic       c_ef, c_af;
    int         c_pos, c_f;

    initial begin
        forever begin
            @(negedge clock);
            if (!reset_n) begin
                for (int k = 0; k < 2; k++)
                    for (int i = 0; i < 4; i++) begin hc[k][i] = 0; dc[k][i] = 0; bc[k][i] = 0; end
            end else begin
                c_pos = bcyc % P;
                c_f = bcyc / P;
                for (int k = 0; k < 2; k++) begin
                    for (int i = 0; i < 4; i++) begin
                        c_ed[i] = m_done[k][i];
                        c_eb[i] = m_busy[k][i];
                        c_es[i] = m_act[k][i] && c_pos >= 1 && c_pos <= m_cur[k][i];
                    end
                    c_ef = (c_pos == 0) && (bcyc != 0);
                    if (k == 0) {c_ad, c_ab, c_as, c_af} = {done8, busy8, sig8, fs8};
                    else        {c_ad, c_ab, c_as, c_af} = {done0, busy0, sig0, fs0};
                    n_vec++;
                    if ({c_ad, c_ab, c_as, c_af} !== {c_ed, c_eb, c_es, c_ef}) begin
                        n_err++;
                        $display("FAIL cycle inst=%0d cyc=%0d got done=%b busy=%b sig=%b fs=%b want done=%b busy=%b sig=%b fs=%b",
                                 k, bcyc, c_ad, c_ab, c_as, c_af, c_ed, c_eb, c_es, c_ef);
                    end
                    for (int i = 0; i < 4; i++) begin
                        hc[k][i] += int'(c_as[i]);
                        dc[k][i] += int'(c_ad[i]);
                        bc[k][i] += int'(c_ab[i]);
                        if (c_pos == P - 1) begin
                            if (c_f < NF) begin
                                hist[k][i][c_f] = hc[k][i]; dh[k][i][c_f] = dc[k][i]; bh[k][i][c_f] = bc[k][i];
                            end
                            hc[k][i] = 0; dc[k][i] = 0; bc[k][i] = 0;
                        end
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic goto(input int f, input int p);
        int tgt = f * P + p;
        int guard = 0;
        while (bcyc != tgt && guard < 60000) begin
            @(negedge clock);
            guard++;
        end
        if (bcyc != tgt) begin
            n_vec++; n_err++;
            $display("FAIL goto got %0d want %0d", bcyc, tgt);
        end
    endtask

    task automatic pulse(input int ch, input int r, input bit d);
        pwm_ratio[ch*8 +: 8] = 8'(r);
        pwm_direction[ch] = d;
        pwm_update[ch] = 1'b1;
        @(negedge clock);
        pwm_update[ch] = 1'b0;
    endtask

    initial begin
        repeat (2) @(negedge clock);
        chk("reset_out_ramp", int'({done8, busy8, sig8, fs8}), 0);
        chk("reset_out_noramp", int'({done0, busy0, sig0, fs0}), 0);
        reset_n = 1'b1;

        goto(0, 5);    pwm_enable = 4'hF;
        goto(0, 10);   pulse(0, 100, 1'b1);
        goto(0, 20);   pulse(1, 40, 1'b0);
        goto(0, 100);  pulse(2, 10, 1'b1);
        goto(0, 200);  pulse(2, 50, 1'b1);
        goto(1, 4095); pulse(2, 0, 1'b1);
        goto(2, 50);   pulse(0, 255, 1'b1);
        goto(3, 50);   pulse(0, 255, 1'b0);
        goto(5, 100);  pulse(3, 20, 1'b1);
        goto(5, 300);  pwm_enable[3] = 1'b0;
        goto(6, 500);  pwm_enable[3] = 1'b1;
        goto(8, 200);

        chk("nr_ch0_f1_high", hist[1][0][1], 733);
        chk("nr_ch0_f0_done", dh[1][0][0], 0);
        chk("nr_ch0_f1_done", dh[1][0][1], 1);
        for (int f = 1; f <= 5; f++) chk($sformatf("rp_ch1_f%0d_high", f), hist[0][1][f], 633 - 8 * f);
        for (int f = 1; f <= 4; f++) chk($sformatf("rp_ch1_f%0d_busy", f), bh[0][1][f] + dh[0][1][f], P);
        chk("rp_ch1_f5_done", dh[0][1][5], 1);
        chk("nr_ch2_f1_high", hist[1][2][1], 683);
        chk("nr_ch2_single_done", dh[1][2][0] + dh[1][2][1], 1);
        chk("nr_ch2_f2_boundary_upd", hist[1][2][2], 633);
        chk("nr_ch0_clamp_hi", hist[1][0][3], 888);
        chk("nr_ch0_clamp_lo", hist[1][0][4], 378);
        chk("rp_ch3_f5_high", hist[0][3][5], 633);
        chk("rp_ch3_f6_high", hist[0][3][6], 0);
        chk("rp_ch3_f6_busy", bh[0][3][6], 0);
        chk("rp_ch3_f7_high", hist[0][3][7], 633);
        chk("rp_ch3_no_done", dh[0][3][5] + dh[0][3][6] + dh[0][3][7], 0);

        chk("pre_reset_sig", int'(sig0), 15);
        #2 reset_n = 1'b0;
        #1;
        chk("mid_reset_ramp", int'({done8, busy8, sig8}), 0);
        chk("mid_reset_noramp", int'({done0, busy0, sig0}), 0);
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        goto(0, 300);
        chk("post_reset_inactive", int'({sig8, sig0}), 0);
        goto(1, 300);
        chk("post_reset_reenabled", int'({sig8, sig0}), 255);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/spark_pwm_multi.md
Name: spark_pwm_multi

Overview:
Multi-channel successor to the single-channel SparkMax PWM generator. It drives NUM_CH independent SparkMax PWM outputs from one shared frame counter, so all pulses start together. Each channel has its own direction/ratio update handshake, output clamping, and an optional per-frame slew limit that ramps the pulse width toward its target. It sits between the register/command layer and the motor-controller pins.

Parameters:
NUM_CH, 4, number of PWM channels
CNT_W, 12, frame counter width
PERIOD, 4096, frame length in clocks (2..2^CNT_W); counter runs 0..PERIOD-1
RATIO_W, 8, width of each ratio field
CENTER, 633, neutral high time in clocks (stopped)
MIN_HIGH, 378, lower clamp on high time (full reverse)
MAX_HIGH, 888, upper clamp on high time (full forward)
RAMP_STEP, 8, maximum high-time change per frame in clocks; 0 = no limit (jump immediately)

Ports:
clock  in  1  main clock
reset_n  in  1  asynchronous active-low reset
pwm_enable  in  NUM_CH  per-channel enable (level)
pwm_ratio  in  NUM_CH*RATIO_W  per-channel ratio; channel i = bits [i*RATIO_W +: RATIO_W]
pwm_direction  in  NUM_CH  1 = forward (CENTER+ratio), 0 = reverse (CENTER-ratio)
pwm_update  in  NUM_CH  per-channel update request (single-cycle pulse)
pwm_done  out  NUM_CH  one-cycle pulse: channel's output has reached the requested target
pwm_busy  out  NUM_CH  1 while an accepted request is pending or ramping
pwm_signal  out  NUM_CH  PWM outputs
frame_start  out  1  one-cycle pulse when the counter wraps to 0

Behaviour:
- One clock domain. Reset is asynchronous and active-low; the async reset is the only one.
- Reset values: counter=0; per-channel cur_high=CENTER, tgt_high=CENTER, active=0, pending=0. All outputs are 0.
- Counter: increments every cycle. It wraps from PERIOD-1 to 0, and frame_start pulses in the cycle where the counter equals 0.
- Target computation at request capture: raw = direction ? CENTER+ratio : CENTER-ratio. Evaluate it signed, CNT_W+1 bits, with no wrap. Clamp the result to [MIN_HIGH, MAX_HIGH].
- Request capture: pwm_update[i]=1 on any cycle latches the clamped target into the request register and sets pending[i] and busy[i].
  - A newer request overwrites an older pending one (last wins).
  - Capture happens every cycle, not only at frame boundaries.
- Frame boundary: the edge where the counter goes PERIOD-1 -> 0. At this edge, per channel:
  - active[i] <= pwm_enable[i]. Enable and disable take effect only at frame boundaries, so a frame is never truncated.
  - If pending: tgt_high <= request, pending <= 0. An update arriving in the same cycle as the boundary is captured and applied at this boundary.
  - cur_high steps toward tgt_high by min(|diff|, RAMP_STEP). If RAMP_STEP=0, cur_high <= tgt_high.
  - A channel that was inactive keeps cur_high=CENTER. On re-enable it starts at neutral and ramps from there.
  - On disable, cur_high and tgt_high reset to CENTER and busy clears. No done pulse is emitted.
- done: pwm_done[i] pulses for exactly one cycle on the cycle after the boundary at which cur_high first equals tgt_high with busy=1. busy clears on the same cycle.
  - A request equal to the current value gives done one cycle after the next boundary.
- Output: pwm_signal[i] is registered from (active[i] && counter < cur_high[i]). It is high for exactly cur_high clocks per frame, delayed one clock from the counter. cur_high is constant within a frame.
- Mid-operation reset: everything returns to reset values asynchronously and outputs go low immediately.
- Channels are fully independent apart from the shared counter.

Decomposition:
- Package spark_pwm_pkg holds:
  - SparkMax defaults: CENTER, MIN_HIGH, MAX_HIGH, PERIOD.
  - A clamp function.
- Sub-module spark_pwm_chan, instantiated NUM_CH times with a generate loop. It holds request capture, clamp, ramp, done/busy and the output register.
- The top holds the shared counter and frame_start.

Test Plan:
- Reset, then enable ch0 with RAMP_STEP=0 and update ratio=100, dir=1 -> next frame ch0 high exactly 733 clocks per 4096 clock period; done pulses once, 1 clock after the boundary.
- RAMP_STEP=8, ch1 from CENTER with update ratio=40, dir=0 -> high times 625, 617, 609, 601, 593 on successive frames; busy=1 throughout, done after the frame reaching 593.
- Clamp: ratio=255, dir=1 -> high=888; ratio=255, dir=0 -> high=378; no wrap.
- Two updates to ch2 within one frame (ratio 10 then 50, dir=1) -> only 683 is applied, with a single done. An update on the exact boundary cycle is applied at that boundary.
- Deassert ch3 enable mid-frame -> the current pulse completes; output is low from the next frame; busy clears; no done. Re-enable -> pulses restart at 633.
- Assert reset_n=0 mid-pulse with all channels active -> pwm_signal, done and busy are 0 immediately; after release all channels stay inactive until enabled.
